// File: rtl/bscane2_tap_if.sv
// Fabric-side bundle of the BSCANE2-compatible access point. The TAP drives
// everything except TDO, which carries the fabric user register's serial output.
interface bscane2_tap_if;
  logic TCK;
  logic TMS;
  logic TDI;
  logic DRCK;
  logic RESET;
  logic RUNTEST;
  logic CAPTURE;
  logic SHIFT;
  logic UPDATE;
  logic SEL;
  logic TDO;

  modport master (
    output TCK, TMS, TDI, DRCK, RESET, RUNTEST, CAPTURE, SHIFT, UPDATE, SEL,
    input  TDO
  );

  modport slave (
    input  TCK, TMS, TDI, DRCK, RESET, RUNTEST, CAPTURE, SHIFT, UPDATE, SEL,
    output TDO
  );
endinterface

// File: rtl/bscane2_tap.sv
// 1149.1 TAP controller with 6-bit IR, IDCODE/BYPASS DRs and one USER access
// point decoded onto SEL; fabric side mirrors the BSCANE2 primitive.
module bscane2_tap #(
  parameter int          JTAG_CHAIN = 1,
  parameter logic [31:0] IDCODE     = 32'h0362D093
) (
  input  logic                jclk,
  input  logic                jreset,
  input  logic                pin_tms,
  input  logic                pin_tdi,
  output logic                pin_tdo,
  bscane2_tap_if.master       bscan,
  output logic [3:0]          o_dbg_state,
  output logic [5:0]          o_dbg_ir
);

  typedef enum logic [3:0] {
    ST_EXIT2_DR = 4'h0,
    ST_EXIT1_DR = 4'h1,
    ST_SHIFT_DR = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EXIT2_IR = 4'h8,
    ST_EXIT1_IR = 4'h9,
    ST_SHIFT_IR = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_t;

  localparam logic [5:0] IR_IDCODE = 6'h09;
  localparam logic [5:0] USER_CODE = (JTAG_CHAIN == 1) ? 6'h02 :
                                     (JTAG_CHAIN == 2) ? 6'h03 :
                                     (JTAG_CHAIN == 3) ? 6'h22 : 6'h23;

  tap_state_t  r_state;
  tap_state_t  w_next;
  logic [5:0]  r_ir;
  logic [5:0]  r_ir_sr;
  logic [31:0] r_id_sr;
  logic        r_bypass;
  logic        w_sel;
  logic        w_is_idcode;

  assign w_sel       = (r_ir == USER_CODE);
  assign w_is_idcode = (r_ir == IR_IDCODE);

  always_ff @(posedge jclk) begin
    if (jreset) begin
      r_state  <= ST_TLR;
      r_ir     <= IR_IDCODE;
      r_ir_sr  <= 6'b000001;
      r_id_sr  <= IDCODE;
      r_bypass <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_TLR:      r_ir    <= IR_IDCODE;
        ST_CAP_IR:   r_ir_sr <= 6'b000001;
        ST_SHIFT_IR: r_ir_sr <= {pin_tdi, r_ir_sr[5:1]};
        ST_UPD_IR:   r_ir    <= r_ir_sr;
        ST_CAP_DR: begin
          if (w_is_idcode)  r_id_sr  <= IDCODE;
          else if (!w_sel)  r_bypass <= 1'b0;
        end
        ST_SHIFT_DR: begin
          if (w_is_idcode)  r_id_sr  <= {pin_tdi, r_id_sr[31:1]};
          else if (!w_sel)  r_bypass <= pin_tdi;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_TLR:      if (!pin_tms) w_next = ST_RTI;
      ST_RTI:      if (pin_tms)  w_next = ST_SEL_DR;
      ST_SEL_DR:   w_next = pin_tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_SEL_IR:   w_next = pin_tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_DR:   w_next = pin_tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: if (pin_tms)  w_next = ST_EXIT1_DR;
      ST_EXIT1_DR: w_next = pin_tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: if (pin_tms)  w_next = ST_EXIT2_DR;
      ST_EXIT2_DR: w_next = pin_tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   w_next = pin_tms ? ST_SEL_DR   : ST_RTI;
      ST_CAP_IR:   w_next = pin_tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: if (pin_tms)  w_next = ST_EXIT1_IR;
      ST_EXIT1_IR: w_next = pin_tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: if (pin_tms)  w_next = ST_EXIT2_IR;
      ST_EXIT2_IR: w_next = pin_tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   w_next = pin_tms ? ST_SEL_DR   : ST_RTI;
      default:     w_next = ST_TLR;
    endcase
  end

  always_comb begin
    pin_tdo = 1'b0;
    if (r_state == ST_SHIFT_IR)      pin_tdo = r_ir_sr[0];
    else if (r_state == ST_SHIFT_DR) begin
      if (w_sel)            pin_tdo = bscan.TDO;
      else if (w_is_idcode) pin_tdo = r_id_sr[0];
      else                  pin_tdo = r_bypass;
    end
  end

  // Strobes are raw state decodes; the fabric must AND them with SEL itself.
  assign bscan.TCK     = jclk;
  assign bscan.TMS     = pin_tms;
  assign bscan.TDI     = pin_tdi;
  assign bscan.RESET   = (r_state == ST_TLR);
  assign bscan.RUNTEST = (r_state == ST_RTI);
  assign bscan.CAPTURE = (r_state == ST_CAP_DR);
  assign bscan.SHIFT   = (r_state == ST_SHIFT_DR);
  assign bscan.UPDATE  = (r_state == ST_UPD_DR);
  assign bscan.SEL     = w_sel;
  assign bscan.DRCK    = (w_sel && (bscan.CAPTURE || bscan.SHIFT)) ? jclk : 1'b1;

  assign o_dbg_state = r_state;
  assign o_dbg_ir    = r_ir;

endmodule

// File: tb/tb_bscane2_tap.sv
// Directed bench for bscane2_tap: reset/IDCODE readout, USER select, fabric DR
// scan strobes, BYPASS, non-matching USER code, TMS reset and jreset mid-scan.
module tb_bscane2_tap;
  logic       jclk = 1'b0;
  logic       jreset;
  logic       pin_tms;
  logic       pin_tdi;
  wire        pin_tdo;
  logic [3:0] dbg_state;
  logic [5:0] dbg_ir;
  int         compared = 0;
  int         mismatched = 0;

  bscane2_tap_if u_if ();

  bscane2_tap #(.JTAG_CHAIN(3), .IDCODE(32'h0362D093)) u_dut (
    .jclk        (jclk),
    .jreset      (jreset),
    .pin_tms     (pin_tms),
    .pin_tdi     (pin_tdi),
    .pin_tdo     (pin_tdo),
    .bscan       (u_if.master),
    .o_dbg_state (dbg_state),
    .o_dbg_ir    (dbg_ir)
  );

  always #5 jclk = ~jclk;

  task automatic tick(input logic tms, input logic tdi);
    pin_tms = tms;
    pin_tdi = tdi;
    @(posedge jclk);
    #1;
  endtask

  // From RTI; ends in UpdIR so callers can observe SEL before the IR commits.
  task automatic shift_ir(input logic [5:0] val, output logic [5:0] tdo_bits);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tdo_bits[i] = pin_tdo;
      tick(i == 5, val[i]);
    end
    tick(1'b1, 1'b0);
  endtask

  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = pin_tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] dout;
    jreset = 1'b1;
    u_if.TDO = 1'b0;
    tick(1'($urandom_range(0, 1)), 1'b0);
    tick(1'($urandom_range(0, 1)), 1'b0);
    compared++;
    if (u_if.RESET !== 1'b1 || dbg_state !== 4'hF) begin
      mismatched++;
      $display("FAIL reset_state: RESET=%b state=%h, want RESET=1 state=f", u_if.RESET, dbg_state);
    end
    compared++;
    if (u_if.SEL !== 1'b0 || dbg_ir !== 6'h09) begin
      mismatched++;
      $display("FAIL reset_ir: SEL=%b ir=%h, want SEL=0 ir=09", u_if.SEL, dbg_ir);
    end
    compared++;
    if ({u_if.CAPTURE, u_if.SHIFT, u_if.UPDATE, u_if.RUNTEST, pin_tdo} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_strobes: cap/shift/upd/rti/tdo=%b, want 00000",
               {u_if.CAPTURE, u_if.SHIFT, u_if.UPDATE, u_if.RUNTEST, pin_tdo});
    end
    #5;
    compared++;
    if (u_if.DRCK !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_drck: DRCK=%b with jclk low, want 1", u_if.DRCK);
    end
    jreset = 1'b0;
    tick(1'b0, 1'b0);
    compared++;
    if (u_if.RUNTEST !== 1'b1) begin
      mismatched++;
      $display("FAIL rti_entry: RUNTEST=%b, want 1", u_if.RUNTEST);
    end
    scan_dr(32'h0, 32, dout);
    compared++;
    if (dout !== 32'h0362D093) begin
      mismatched++;
      $display("FAIL idcode_scan: got %h, want 0362d093", dout);
    end
  endtask

  task automatic test_passthru();
    pin_tms = 1'b1;
    pin_tdi = 1'b0;
    #1;
    compared++;
    if (u_if.TMS !== 1'b1 || u_if.TDI !== 1'b0 || u_if.TCK !== 1'b1) begin
      mismatched++;
      $display("FAIL passthru_a: TMS/TDI/TCK=%b, want 101", {u_if.TMS, u_if.TDI, u_if.TCK});
    end
    pin_tms = 1'b0;
    pin_tdi = 1'b1;
    #4;
    compared++;
    if (u_if.TMS !== 1'b0 || u_if.TDI !== 1'b1 || u_if.TCK !== 1'b0) begin
      mismatched++;
      $display("FAIL passthru_b: TMS/TDI/TCK=%b, want 010", {u_if.TMS, u_if.TDI, u_if.TCK});
    end
  endtask

  task automatic test_user_sel();
    logic [5:0] bits;
    shift_ir(6'h22, bits);
    compared++;
    if (bits !== 6'b000001) begin
      mismatched++;
      $display("FAIL ir_capture_out: got %b (LSB first read), want 000001", bits);
    end
    compared++;
    if (u_if.SEL !== 1'b0) begin
      mismatched++;
      $display("FAIL sel_in_updir: SEL=%b, want 0", u_if.SEL);
    end
    tick(1'b0, 1'b0);
    compared++;
    if (u_if.SEL !== 1'b1 || dbg_ir !== 6'h22) begin
      mismatched++;
      $display("FAIL sel_after_updir: SEL=%b ir=%h, want SEL=1 ir=22", u_if.SEL, dbg_ir);
    end
  endtask

  task automatic test_user_dr();
    int cap_cnt = 0, shift_cnt = 0, upd_cnt = 0, drck_low = 0, tdo_err = 0;
    logic tms;
    for (int k = 0; k < 37; k++) begin
      tms = (k == 0) || (k == 34) || (k == 35);
      tick(tms, 1'b0);
      cap_cnt   += int'(u_if.CAPTURE);
      shift_cnt += int'(u_if.SHIFT);
      upd_cnt   += int'(u_if.UPDATE);
      #5;
      drck_low += int'(u_if.DRCK == 1'b0);
      if (u_if.SHIFT) begin
        u_if.TDO = 1'($urandom_range(0, 1));
        #1;
        if (pin_tdo !== u_if.TDO) tdo_err++;
      end
    end
    compared++;
    if (cap_cnt != 1 || shift_cnt != 32 || upd_cnt != 1) begin
      mismatched++;
      $display("FAIL user_dr_strobes: cap=%0d shift=%0d upd=%0d, want 1/32/1", cap_cnt, shift_cnt, upd_cnt);
    end
    compared++;
    if (drck_low != 33) begin
      mismatched++;
      $display("FAIL user_dr_drck: low samples=%0d, want 33", drck_low);
    end
    compared++;
    if (tdo_err != 0) begin
      mismatched++;
      $display("FAIL user_dr_tdo: %0d cycles pin_tdo!=TDO, want 0", tdo_err);
    end
    compared++;
    if (u_if.SEL !== 1'b1 || u_if.RUNTEST !== 1'b1) begin
      mismatched++;
      $display("FAIL user_dr_end: SEL=%b RUNTEST=%b, want 1/1", u_if.SEL, u_if.RUNTEST);
    end
  endtask

  task automatic test_bypass();
    logic [5:0]  bits;
    logic [31:0] dout;
    shift_ir(6'h3F, bits);
    tick(1'b0, 1'b0);
    compared++;
    if (u_if.SEL !== 1'b0 || dbg_ir !== 6'h3F) begin
      mismatched++;
      $display("FAIL bypass_ir: SEL=%b ir=%h, want SEL=0 ir=3f", u_if.SEL, dbg_ir);
    end
    scan_dr(32'hA5, 8, dout);
    compared++;
    if (dout !== 32'h0000004A) begin
      mismatched++;
      $display("FAIL bypass_scan: got %h, want 0000004a", dout);
    end
  endtask

  task automatic test_user1_unsel();
    logic [5:0] bits;
    int cap_cnt = 0, shift_cnt = 0, upd_cnt = 0, drck_low = 0;
    logic tms;
    shift_ir(6'h02, bits);
    tick(1'b0, 1'b0);
    compared++;
    if (u_if.SEL !== 1'b0 || dbg_ir !== 6'h02) begin
      mismatched++;
      $display("FAIL user1_ir: SEL=%b ir=%h, want SEL=0 ir=02", u_if.SEL, dbg_ir);
    end
    for (int k = 0; k < 9; k++) begin
      tms = (k == 0) || (k == 6) || (k == 7);
      tick(tms, 1'b1);
      cap_cnt   += int'(u_if.CAPTURE);
      shift_cnt += int'(u_if.SHIFT);
      upd_cnt   += int'(u_if.UPDATE);
      #5;
      drck_low += int'(u_if.DRCK == 1'b0);
    end
    compared++;
    if (cap_cnt != 1 || shift_cnt != 4 || upd_cnt != 1 || drck_low != 0) begin
      mismatched++;
      $display("FAIL user1_strobes: cap=%0d shift=%0d upd=%0d drck_low=%0d, want 1/4/1/0",
               cap_cnt, shift_cnt, upd_cnt, drck_low);
    end
  endtask

  task automatic test_tms_reset();
    logic [5:0] bits;
    shift_ir(6'h22, bits);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    compared++;
    if (u_if.RESET !== 1'b0) begin
      mismatched++;
      $display("FAIL tms_reset_4: RESET=%b after 4 TMS=1, want 0", u_if.RESET);
    end
    tick(1'b1, 1'b0);
    compared++;
    if (u_if.RESET !== 1'b1) begin
      mismatched++;
      $display("FAIL tms_reset_5: RESET=%b after 5 TMS=1, want 1", u_if.RESET);
    end
    tick(1'b1, 1'b0);
    compared++;
    if (dbg_ir !== 6'h09 || u_if.SEL !== 1'b0 || u_if.RESET !== 1'b1) begin
      mismatched++;
      $display("FAIL tms_reset_ir: ir=%h SEL=%b RESET=%b, want 09/0/1", dbg_ir, u_if.SEL, u_if.RESET);
    end
  endtask

  task automatic test_jreset_ir();
    logic [5:0]  bits;
    logic [31:0] dout;
    tick(1'b0, 1'b0);
    shift_ir(6'h22, bits);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    jreset = 1'b1;
    tick(1'b1, 1'b1);
    compared++;
    if (u_if.RESET !== 1'b1 || dbg_ir !== 6'h09 || u_if.SEL !== 1'b0) begin
      mismatched++;
      $display("FAIL jreset_mid_ir: RESET=%b ir=%h SEL=%b, want 1/09/0", u_if.RESET, dbg_ir, u_if.SEL);
    end
    jreset = 1'b0;
    tick(1'b1, 1'b0);
    compared++;
    if (dbg_ir !== 6'h09 || u_if.RESET !== 1'b1) begin
      mismatched++;
      $display("FAIL jreset_hold: ir=%h RESET=%b, want 09/1", dbg_ir, u_if.RESET);
    end
    tick(1'b0, 1'b0);
    scan_dr(32'h0, 32, dout);
    compared++;
    if (dout !== 32'h0362D093) begin
      mismatched++;
      $display("FAIL idcode_after_jreset: got %h, want 0362d093", dout);
    end
  endtask

  initial begin
    pin_tms = 1'b1;
    pin_tdi = 1'b0;
    jreset  = 1'b1;
    test_reset();
    test_passthru();
    test_user_sel();
    test_user_dr();
    test_bypass();
    test_user1_unsel();
    test_tms_reset();
    test_jreset_ir();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bscane2_tap.md
# bscane2_tap

Behavioural, synthesizable model of the 7‑series JTAG TAP with one USER boundary‑scan access point. It contains the IEEE 1149.1 16‑state TAP controller, a 6‑bit instruction register, BYPASS and IDCODE data registers, and decodes one USER instruction into `SEL`. It sits between the board‑level JTAG pins and a fabric user data register, such as the system info interface. Its fabric‑side ports match the BSCANE2 primitive, so fabric logic simulates unchanged.

## Interface
- `JTAG_CHAIN`, 1: USER instruction served; 1..4 → USER1..USER4 = 6'h02, 6'h03, 6'h22, 6'h23.
- `IDCODE`, 32'h0362D093: value captured by the IDCODE instruction (6'h09).
- `jclk` in 1: JTAG TCK pin, the only clock. All state updates on its rising edge.
- `jreset` in 1: reset, synchronous, active‑high. Forces Test‑Logic‑Reset.
- `pin_tms` in 1: TMS pin.
- `pin_tdi` in 1: TDI pin.
- `pin_tdo` out 1: TDO pin.
- `TCK` out 1: equals `jclk`.
- `TMS` out 1: equals `pin_tms`.
- `TDI` out 1: equals `pin_tdi`.
- `DRCK` out 1: `jclk` when `SEL & (CAPTURE | SHIFT)`, else 1.
- `RESET` out 1: state == Test‑Logic‑Reset.
- `RUNTEST` out 1: state == Run‑Test/Idle.
- `CAPTURE` out 1: state == Capture‑DR.
- `SHIFT` out 1: state == Shift‑DR.
- `UPDATE` out 1: state == Update‑DR.
- `SEL` out 1: IR == USER code of `JTAG_CHAIN`.
- `TDO` in 1: fabric user‑register serial output.

## Operation
- **TAP FSM.** Standard 1149.1 graph, advanced on each `jclk` rise by `pin_tms`.
  - TLR: tms0 → RTI.
  - RTI: tms1 → SelDR.
  - SelDR: 0 → CapDR, 1 → SelIR.
  - SelIR: 0 → CapIR, 1 → TLR.
  - CapX: 0 → ShiftX, 1 → Exit1X.
  - ShiftX: 1 → Exit1X.
  - Exit1X: 0 → PauseX, 1 → UpdX.
  - PauseX: 1 → Exit2X.
  - Exit2X: 0 → ShiftX, 1 → UpdX.
  - UpdX: 0 → RTI, 1 → SelDR.
  - Unlisted TMS values hold the state.
- **Reset.** `jreset` = 1 at a clock edge sets state = TLR and IR = 6'h09 (IDCODE). Reset wins over any other activity, including in the middle of a scan.
  - Every clock spent in TLR also reloads IR = 6'h09.
  - Five consecutive `pin_tms` = 1 clocks reach TLR from any state.
- **Instruction register.**
  - CapIR edge: `ir_sr` ← 6'b000001.
  - ShiftIR edge: `ir_sr` ← {`pin_tdi`, `ir_sr[5:1]`}.
  - UpdIR edge: IR ← `ir_sr`.
- **Data registers.** The IR selects the DR.
  - IDCODE: CapDR loads `IDCODE`; ShiftDR shifts right with `pin_tdi` into bit 31.
  - USER code matching `JTAG_CHAIN`: the fabric register is used; no internal DR activity.
  - Any other code: the 1‑bit BYPASS register. CapDR loads 0; ShiftDR loads `pin_tdi`.
- **`pin_tdo`** is combinational:
  - ShiftIR → `ir_sr[0]`.
  - ShiftDR → `TDO` if `SEL`, `id_sr[0]` if IDCODE, otherwise the bypass bit.
  - Any other state → 0.
- **Fabric strobes.** `CAPTURE`, `SHIFT`, `UPDATE`, `RESET` and `RUNTEST` are pure decodes of the registered state. They are **not** qualified by `SEL`; fabric logic must AND with `SEL`.

## Timing
- After reset: `RESET` = 1, `SEL` = 0, `CAPTURE`/`SHIFT`/`UPDATE`/`RUNTEST` = 0, `pin_tdo` = 0, `DRCK` = 1.
- State and IR change only on `jclk` rise. Decoded outputs are valid for the whole following cycle, so fabric sampling at the next rise sees each strobe exactly once per cycle spent in that state.
- `CAPTURE` and `UPDATE` last one cycle per pass. `SHIFT` lasts N cycles for an N‑clock shift and resumes after Pause/Exit2.
- `SEL` changes at the rise that leaves UpdIR, and stays stable through DR scans.
- A scan of N bits ends with the Nth bit shifted on the ShiftDR→Exit1DR edge (TMS = 1 on the last bit). `pin_tdo` presents the current LSB before each shifting edge.
- `TCK`, `TMS`, `TDI` and `DRCK` are zero‑latency combinational.

## Test plan
- Assert `jreset` for 2 clocks with random `pin_tms` → `RESET` = 1, `SEL` = 0, IR = 6'h09. A DR scan then shifts out 32'h0362D093 LSB first on `pin_tdo`.
- `JTAG_CHAIN` = 3, shift IR 6'h22 → `SEL` = 1 from the clock after UpdIR. During the IR shift, `pin_tdo` outputs 1,0,0,0,0,0.
- With `SEL` = 1, do a DR scan of 32 bits → `CAPTURE` 1 cycle, `SHIFT` 32 cycles, `UPDATE` 1 cycle, `DRCK` toggling only in CapDR/ShiftDR. `pin_tdo` equals fabric `TDO` each shift cycle.
- Load IR 6'h3F (BYPASS) and shift 8 bits 8'hA5 → `pin_tdo` shows 0 then `pin_tdi` delayed by one clock; `SEL` = 0.
- Load USER1 (6'h02) with `JTAG_CHAIN` = 3 → `SEL` = 0, while `CAPTURE`/`SHIFT`/`UPDATE` still pulse during a DR scan.
- Mid‑ShiftDR, apply five `pin_tms` = 1 clocks → `RESET` = 1, IR = 6'h09, `SEL` = 0. Repeat with `jreset` mid‑ShiftIR → TLR on the next edge, IR not updated from `ir_sr`.
